// File: rtl/fft_stage_ctrl.sv
// Sequencing controller for one radix-2 FFT butterfly stage: accepts frames of
// NUM_BLK blocks, drives stage enable / twiddle base, and delays output markers.
module fft_stage_ctrl #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 512,
  parameter int NUM_BLK    = 4,
  parameter int BFLY_LAT   = 2,
  parameter int IDX_W      = $clog2(BLOCK_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       bfly_en,
  output logic [IDX_W-1:0]           twf_base,
  output logic [$clog2(NUM_BLK):0]   blk_idx,
  output logic                       dout_valid,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic                       busy,
  output logic                       done,
  output logic                       err_start
);

  localparam int CPB   = BLOCK_SIZE / (2 * N);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BLK_W = $clog2(NUM_BLK) + 1;
  localparam int DRN_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic v;
    logic sop;
    logic eop;
  } tag_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [BLK_W-1:0]          blk_idx_q, blk_idx_d;
  logic [DRN_W-1:0]          drn_cnt_q, drn_cnt_d;
  tag_t [BFLY_LAT-1:0]       tag_sr_q, tag_sr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic accept;
  logic last_beat;
  logic last_blk;

  // Twiddle address path is combinational so the ROM sees it in the beat's own cycle.
  assign din_ready = (state_q == RUN);
  assign accept    = din_ready & din_valid;
  assign bfly_en   = accept;
  assign twf_base  = accept ? IDX_W'(beat_cnt_q) * IDX_W'(2 * N) : '0;
  assign last_beat = (beat_cnt_q == CNT_W'(CPB - 1));
  assign last_blk  = (blk_idx_q == BLK_W'(NUM_BLK - 1));

  always_comb begin
    // NOTE: every _d gets a default here first; a missed branch would otherwise infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    blk_idx_d  = blk_idx_q;
    drn_cnt_d  = drn_cnt_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          beat_cnt_d = '0;
          blk_idx_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            blk_idx_d  = blk_idx_q + BLK_W'(1);
            if (last_blk) begin
              state_d   = DRAIN;
              drn_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drn_cnt_q == DRN_W'(BFLY_LAT - 1)) state_d = IDLE;
        else                                   drn_cnt_d = drn_cnt_q + DRN_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Starts while a frame is active (including the done cycle) are dropped and flagged.
    if (start && (state_q != IDLE)) err_d = 1'b1;

    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN) && (drn_cnt_d == DRN_W'(BFLY_LAT - 1));

    tag_sr_d[0] = '{v: accept, sop: accept && (beat_cnt_q == '0), eop: accept && last_beat};
    for (int i = 1; i < BFLY_LAT; i++) tag_sr_d[i] = tag_sr_q[i-1];
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      blk_idx_q  <= '0;
      drn_cnt_q  <= '0;
      tag_sr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      blk_idx_q  <= blk_idx_d;
      drn_cnt_q  <= drn_cnt_d;
      tag_sr_q   <= tag_sr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign blk_idx    = blk_idx_q;
  assign dout_valid = tag_sr_q[BFLY_LAT-1].v;
  assign dout_sop   = tag_sr_q[BFLY_LAT-1].sop;
  assign dout_eop   = tag_sr_q[BFLY_LAT-1].eop;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_start  = err_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: table of frame scenarios at default
// parameters, plus reset-abort and small-parameter sequences.
module tb_fft_stage_ctrl;

  localparam int CPB   = 32;
  localparam int TOTAL = 128;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, din_valid = 1'b0;
  logic       din_ready, bfly_en, dout_valid, dout_sop, dout_eop, busy, done, err_start;
  logic [8:0] twf_base;
  logic [2:0] blk_idx;

  logic       start2 = 1'b0, din_valid2 = 1'b0;
  logic       din_ready2, bfly_en2, dout_valid2, dout_sop2, dout_eop2, busy2, done2, err_start2;
  logic [5:0] twf_base2;
  logic [0:0] blk_idx2;

  fft_stage_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din_ready(din_ready),
    .bfly_en(bfly_en), .twf_base(twf_base), .blk_idx(blk_idx), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy), .done(done), .err_start(err_start)
  );

  fft_stage_ctrl #(.N(4), .BLOCK_SIZE(64), .NUM_BLK(1), .BFLY_LAT(3), .IDX_W(6)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din_valid(din_valid2), .din_ready(din_ready2),
    .bfly_en(bfly_en2), .twf_base(twf_base2), .blk_idx(blk_idx2), .dout_valid(dout_valid2),
    .dout_sop(dout_sop2), .dout_eop(dout_eop2), .busy(busy2), .done(done2), .err_start(err_start2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Stall a/b: drop din_valid for la/lb cycles when beat sa/sb is next.
  // sp1/sp2: cycles carrying a spurious start. gap: expected eop-sop distance (0 = skip).
  typedef struct {
    int sa, la, sb, lb;
    int sp1, sp2;
    int done_cyc;
    int gap;
    int err;
  } frame_vec_t;

  frame_vec_t vecs[4];

  // Cycle n of a frame is the n-th cycle after the edge that samples start.
  task automatic run_frame(input frame_vec_t v, input int row);
    bit hv[0:511], hs[0:511], he[0:511];
    int beats = 0, stall_left = 0, sops = 0, eops = 0, sop_cyc = 0, eop_cyc = 0, done_cyc = 0;
    bit used_a = 0, used_b = 0, acc, ev, es, ee;
    din_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 400 && done_cyc == 0; cyc++) begin
      if (!used_a && beats == v.sa) begin stall_left = v.la; used_a = 1; end
      if (!used_b && beats == v.sb) begin stall_left = v.lb; used_b = 1; end
      acc = (beats < TOTAL) && (stall_left == 0);
      if (stall_left > 0) stall_left--;
      din_valid = acc;
      start = (cyc == v.sp1) || (cyc == v.sp2);
      #3;
      check($sformatf("r%0d c%0d bfly_en", row, cyc), bfly_en, acc);
      check($sformatf("r%0d c%0d din_ready", row, cyc), din_ready, beats < TOTAL);
      if (acc) begin
        check($sformatf("r%0d b%0d twf_base", row, beats), twf_base, (beats % CPB) * 16);
        check($sformatf("r%0d b%0d blk_idx", row, beats), blk_idx, beats / CPB);
      end
      hv[cyc] = acc;
      hs[cyc] = acc && (beats % CPB == 0);
      he[cyc] = acc && (beats % CPB == CPB - 1);
      ev = (cyc > LAT) ? hv[cyc-LAT] : 1'b0;
      es = (cyc > LAT) ? hs[cyc-LAT] : 1'b0;
      ee = (cyc > LAT) ? he[cyc-LAT] : 1'b0;
      check($sformatf("r%0d c%0d dout_valid", row, cyc), dout_valid, ev);
      check($sformatf("r%0d c%0d dout_sop", row, cyc), dout_sop, es);
      check($sformatf("r%0d c%0d dout_eop", row, cyc), dout_eop, ee);
      check($sformatf("r%0d c%0d busy", row, cyc), busy, 1);
      if (dout_sop === 1'b1) begin
        sops++;
        if (sops > 1) check($sformatf("r%0d sop after eop", row), cyc - eop_cyc, 1);
        sop_cyc = cyc;
      end
      if (dout_eop === 1'b1) begin
        eops++;
        if (v.gap > 0) check($sformatf("r%0d eop-sop gap", row), cyc - sop_cyc, v.gap);
        eop_cyc = cyc;
      end
      if (acc) beats++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        check($sformatf("r%0d done cycle", row), cyc, v.done_cyc);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    din_valid = 1'b0;
    if (done_cyc == 0) check($sformatf("r%0d done timeout", row), 0, 1);
    #3;
    check($sformatf("r%0d busy after", row), busy, 0);
    check($sformatf("r%0d done pulse width", row), done, 0);
    check($sformatf("r%0d sop count", row), sops, 4);
    check($sformatf("r%0d eop count", row), eops, 4);
    check($sformatf("r%0d err_start", row), err_start, v.err);
    @(posedge clk); #1;
  endtask

  task automatic run_reset_test();
    int seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din_valid = 1'b1;
    repeat (17) @(posedge clk);
    #2;
    check("rst pre twf_base", twf_base, 17 * 16);
    rst = 1'b1;
    #1;
    check("rst din_ready", din_ready, 0);
    check("rst bfly_en", bfly_en, 0);
    check("rst twf_base", twf_base, 0);
    check("rst blk_idx", blk_idx, 0);
    check("rst dout_valid", dout_valid, 0);
    check("rst dout_sop", dout_sop, 0);
    check("rst dout_eop", dout_eop, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err_start", err_start, 0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (140) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("rst no done/busy after abort", seen, 0);
  endtask

  task automatic run_sweep();
    int beats = 0, done_cyc = 0;
    bit acc;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int cyc = 1; cyc < 40 && done_cyc == 0; cyc++) begin
      acc = (beats < 8);
      din_valid2 = acc;
      #3;
      check($sformatf("sw c%0d bfly_en", cyc), bfly_en2, acc);
      if (acc) check($sformatf("sw b%0d twf_base", beats), twf_base2, beats * 8);
      check($sformatf("sw c%0d dout_valid", cyc), dout_valid2, (cyc >= 4) && (cyc <= 11));
      check($sformatf("sw c%0d dout_sop", cyc), dout_sop2, cyc == 4);
      check($sformatf("sw c%0d dout_eop", cyc), dout_eop2, cyc == 11);
      if (acc) beats++;
      if (done2 === 1'b1) begin
        done_cyc = cyc;
        check("sw done cycle", cyc, 11);
      end
      @(posedge clk); #1;
    end
    din_valid2 = 1'b0;
    if (done_cyc == 0) check("sw done timeout", 0, 1);
    #3;
    check("sw busy after", busy2, 0);
    check("sw err_start", err_start2, 0);
  endtask

  initial begin
    vecs[0] = '{sa: -1, la: 0, sb: -1, lb: 0, sp1: -1, sp2: -1, done_cyc: 130, gap: 31, err: 0};
    vecs[1] = '{sa: 10, la: 3, sb: 31, lb: 1, sp1: -1, sp2: -1, done_cyc: 134, gap: 0,  err: 0};
    vecs[2] = '{sa: -1, la: 0, sb: -1, lb: 0, sp1: 50, sp2: 129, done_cyc: 130, gap: 31, err: 1};
    vecs[3] = '{sa: -1, la: 0, sb: -1, lb: 0, sp1: 130, sp2: -1, done_cyc: 130, gap: 31, err: 1};

    #2;
    check("init din_ready", din_ready, 0);
    check("init busy", busy, 0);
    check("init dout_valid", dout_valid, 0);
    check("init twf_base", twf_base, 0);
    check("init blk_idx", blk_idx, 0);
    check("init err_start", err_start, 0);
    check("init done", done, 0);
    check("init busy2", busy2, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 4; r++) run_frame(vecs[r], r);
    run_reset_test();
    @(posedge clk); #1;
    run_frame(vecs[0], 4);
    run_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
